instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/rv_pkg.sv | 39 +++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV front end:
//   - datapath widths (XLEN, INSTR_W)
//   - depth of the fetch response buffer (FIFO_DEPTH)
//   - default reset PC (RESET_PC_DEFAULT)
//   - fetch FSM state type
//   - buffered fetch entry {pc, instr}
//   - pc_fetchable(): true when a PC may legally be fetched from a memory of
//     the given size (word aligned and the whole word inside memory)
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // The end address is computed one bit wider so that a PC near 2^32
    // cannot wrap around and look like it is inside memory.
    function automatic logic pc_fetchable(input logic [XLEN-1:0] pc,
                                          input int unsigned     imem_bytes);
        logic [XLEN:0] end_addr;
        end_addr = {1'b0, pc} + 33'd4;
        return (pc[1:0] == 2'b00) && (end_addr <= 33'(imem_bytes));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small circular buffer of fetched {pc, instr} entries sitting between the
// instruction memory and decode.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   flush        drop every buffered entry (redirect)
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          remove the head entry (ignored when empty)
//   head         current head entry
//   full, empty  occupancy flags
//
// A push is accepted while full if a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = entries[rd_ptr];

    // Storage and pointers. Reset also clears the storage so the head reads
    // as zero afterwards; flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Sequential instruction fetch unit with redirect support and a 2-entry
// response buffer towards decode.
//
// Parameters:
//   RESET_PC     PC loaded on reset
//   IMEM_BYTES   size of the addressable instruction memory in bytes
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   imem_addr        byte address of the word being fetched
//   imem_req         imem_addr is a valid fetch this cycle
//   imem_rdata       little-endian word, returned one cycle after imem_req
//   redirect_valid   branch/JALR redirect strobe
//   redirect_pc      redirect target
//   out_valid        instruction available to decode
//   out_ready        decode accepts the instruction
//   out_instr        fetched instruction
//   out_pc           address of out_instr
//   fault            sticky fetch fault (misaligned or out-of-range PC)
// ----------------------------------------------------------------------------
module instruction_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     IMEM_BYTES = 128
) (
    input  logic               clk,
    input  logic               reset,
    output logic [XLEN-1:0]    imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               fault
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] in_flight_pc;
    logic            in_flight;
    logic            fault_q;
    logic            fault_next;
    logic            issue;
    logic            pop;
    logic            push;
    logic            has_room;
    logic [1:0]      fifo_occupancy;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;

    // A response is captured the cycle after its issue unless a redirect in
    // this cycle throws it away. A response landing during reset is lost
    // because the buffer reset has priority, and in_flight is cleared by
    // reset so nothing from before the reset is captured afterwards.
    assign pop        = out_valid && out_ready;
    assign push       = in_flight && !redirect_valid;
    assign push_entry = '{pc: in_flight_pc, instr: imem_rdata};

    // Only issue if the buffer can still hold the response when it returns:
    // what is buffered plus what is in flight, minus what leaves this cycle.
    assign fifo_occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign has_room = (3'(fifo_occupancy) + 3'(in_flight)) < (3'(FIFO_DEPTH) + 3'(pop));

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fetch FSM state, PC, fault flag and the tag of the outstanding fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            pc           <= RESET_PC;
            fault_q      <= 1'b0;
            in_flight    <= 1'b0;
            in_flight_pc <= RESET_PC;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            fault_q   <= fault_next;
            in_flight <= issue;
            if (issue) begin
                in_flight_pc <= pc;
            end
        end
    end

    // Next-state and issue decision. A redirect overrides everything: it never
    // issues in its own cycle, and its target alone decides whether fetch
    // resumes (RUN) or stops with a fault (HALT). In RUN an illegal PC is
    // only noticed when a fetch would otherwise go out.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        fault_next = fault_q;
        issue      = 1'b0;
        if (redirect_valid) begin
            pc_next = redirect_pc;
            if (pc_fetchable(redirect_pc, IMEM_BYTES)) begin
                state_next = ST_RUN;
                fault_next = 1'b0;
            end else begin
                state_next = ST_HALT;
                fault_next = 1'b1;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (has_room) begin
                        if (pc_fetchable(pc, IMEM_BYTES)) begin
                            issue   = 1'b1;
                            pc_next = pc + 32'd4;
                        end else begin
                            state_next = ST_HALT;
                            fault_next = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                end
            endcase
        end
    end

    // Outputs are forced to their reset values while reset is held.
    assign imem_req  = issue && !reset;
    assign imem_addr = reset ? RESET_PC : pc;
    assign out_valid = !fifo_empty && !reset;
    assign out_instr = reset ? '0 : fifo_head.instr;
    assign out_pc    = reset ? '0 : fifo_head.pc;
    assign fault     = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch. The stimulus process drives the
// inputs and, whenever a reset or redirect takes effect, replaces the expected
// instruction stream with "every word from the new PC up to the end of memory".
// A separate monitor pops that stream on every accepted transfer and also
// checks fetch legality and output stability while decode stalls.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES = 128;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expect_q[$];
    logic [7:0]  mem [IMEM_BYTES];
    logic        last_rst;
    logic        last_rv;
    logic [31:0] last_rpc;

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit addr_legal(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la % 4 == 0) && (la + 4 <= longint'(IMEM_BYTES));
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int i;
        if (!addr_legal(a)) return 32'hDEAD_BEEF;
        i = int'(a);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    // Memory answers one cycle after a request; garbage otherwise.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= $urandom;
    end

    task automatic rebuildExpected(input logic [31:0] start);
        expect_q.delete();
        for (longint a = longint'(start); (a % 4 == 0) && (a + 4 <= longint'(IMEM_BYTES)); a += 4) begin
            expect_q.push_back('{pc: 32'(a), instr: mem_word(32'(a))});
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: the posedge closing the previous cycle folds its reset or
    // redirect into the expected stream, then new inputs are driven and the
    // task returns at the negedge where outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        if (last_rst)     rebuildExpected(RESET_PC);
        else if (last_rv) rebuildExpected(last_rpc);
        #1;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        last_rst       = rst;
        last_rv        = rv;
        last_rpc       = rpc;
        @(negedge clk);
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        while (expect_q.size() != 0 && n < max_cycles) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        checkOutput("drain_left", 32'(expect_q.size()), 32'd0);
    endtask

    // Monitor: legality of every fetch, no fetch during reset/redirect,
    // stability while stalled, and in-order delivery of the expected stream.
    logic        stall_prev = 1'b0;
    logic [31:0] held_pc;
    logic [31:0] held_instr;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (imem_req === 1'b1) begin
            checkOutput("imem_addr_legal", {31'b0, addr_legal(imem_addr)}, 32'd1);
        end
        if (reset === 1'b1 || redirect_valid === 1'b1) begin
            checkOutput("req_blocked", {31'b0, imem_req}, 32'd0);
        end
        if (stall_prev && reset !== 1'b1) begin
            checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_pc", out_pc, held_pc);
            checkOutput("hold_instr", out_instr, held_instr);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expect_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_transfer: got pc 0x%08h instr 0x%08h, expected no transfer at %0t",
                         out_pc, out_instr, $time);
            end else begin
                e = expect_q.pop_front();
                checkOutput("out_pc", out_pc, e.pc);
                checkOutput("out_instr", out_instr, e.instr);
            end
        end
        stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1) &&
                     (redirect_valid !== 1'b1) && (reset !== 1'b1);
        held_pc    = out_pc;
        held_instr = out_instr;
    end

    initial begin
        logic        rst_r;
        logic        rv_r;
        logic        rdy_r;
        logic [31:0] tgt;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        last_rst       = 1'b1;
        last_rv        = 1'b0;
        last_rpc       = 32'h0;
        for (int i = 0; i < IMEM_BYTES; i++) mem[i] = 8'($urandom);
        mem[0]  = 8'hB3; mem[1]  = 8'h81; mem[2]  = 8'h20; mem[3]  = 8'h00;
        mem[32] = 8'hB3; mem[33] = 8'hA1; mem[34] = 8'h20; mem[35] = 8'h40;

        // Reset values
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, RESET_PC);
        checkOutput("rst_fault", {31'b0, fault}, 32'd0);

        // First fetch and its two-cycle latency to out_valid
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("first_req", {31'b0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, RESET_PC);
        checkOutput("lat0_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("lat1_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("lat2_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("first_instr", out_instr, 32'h0020_81B3);
        checkOutput("first_pc", out_pc, 32'h0);

        // Streaming: one instruction per cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("stream_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stream_pc", out_pc, 32'(4 * i));
            if (i == 8) checkOutput("stream_instr_32", out_instr, 32'h4020_A1B3);
        end

        // Decode stalls for 5 cycles, then resumes
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x20 while a fetch is in flight
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redir_flush1", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redir_flush2", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redir_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("redir_pc", out_pc, 32'h20);
        checkOutput("redir_instr", out_instr, 32'h4020_A1B3);

        // Misaligned redirect (coincident with a pop) faults immediately
        applyStimulus(1'b0, 1'b1, 32'h22, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mis_fault", {31'b0, fault}, 32'd1);
        checkOutput("mis_no_req", {31'b0, imem_req}, 32'd0);
        checkOutput("mis_no_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("halt_no_req", {31'b0, imem_req}, 32'd0);

        // Valid redirect clears fault, then run off the end of memory
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("clr_fault", {31'b0, fault}, 32'd0);
        checkOutput("resume_req", {31'b0, imem_req}, 32'd1);
        checkOutput("resume_addr", imem_addr, 32'h0);
        waitDrain(150);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("end_fault", {31'b0, fault}, 32'd1);
        checkOutput("end_no_req", {31'b0, imem_req}, 32'd0);
        checkOutput("end_no_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("end_clr_fault", {31'b0, fault}, 32'd0);

        // Reset with two entries buffered
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_fault", {31'b0, fault}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_r = ($urandom_range(0, 99) == 0);
            rv_r  = !rst_r && ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 7) == 0) tgt = 32'($urandom_range(0, 255));
            else                           tgt = 32'($urandom_range(0, 31)) << 2;
            rdy_r = ($urandom_range(0, 3) != 0);
            applyStimulus(rst_r, rv_r, tgt, rdy_r);
        end
        waitDrain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
